// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the golden-trace checker: record layout, mismatch mask bits, FSM states.
package cpu_trace_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RADDR_W   = 5;
    localparam int unsigned REC_W     = 102;
    localparam int unsigned MASK_W    = 5;

    localparam int unsigned PC_LSB    = 70;
    localparam int unsigned INST_LSB  = 38;
    localparam int unsigned WE_BIT    = 37;
    localparam int unsigned WADDR_LSB = 32;
    localparam int unsigned WDATA_LSB = 0;

    localparam int unsigned MASK_PC    = 0;
    localparam int unsigned MASK_INST  = 1;
    localparam int unsigned MASK_WE    = 2;
    localparam int unsigned MASK_WADDR = 3;
    localparam int unsigned MASK_WDATA = 4;

    // Field order mirrors the ROM record layout, MSB first.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    inst;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [XLEN-1:0]    wdata;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/trace_record_cmp.sv
// Compares one expected trace record against a live commit and reports which fields differ.
module trace_record_cmp
    import cpu_trace_pkg::*;
(
    input  logic [REC_W-1:0]   rec_data,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [XLEN-1:0]    commit_inst,
    input  logic               commit_rf_we,
    input  logic [RADDR_W-1:0] commit_rf_waddr,
    input  logic [XLEN-1:0]    commit_rf_wdata,
    output logic [MASK_W-1:0]  mask_c
);

    trace_rec_t rec;

    assign rec = trace_rec_t'(rec_data);

    // Destination fields only matter when a write is expected; writes to r0 carry no data.
    always_comb begin
        mask_c             = '0;
        mask_c[MASK_PC]    = (rec.pc   != commit_pc);
        mask_c[MASK_INST]  = (rec.inst != commit_inst);
        mask_c[MASK_WE]    = (rec.we   != commit_rf_we);
        if (rec.we) begin
            mask_c[MASK_WADDR] = (rec.waddr != commit_rf_waddr);
            if (rec.waddr != '0) begin
                mask_c[MASK_WDATA] = (rec.wdata != commit_rf_wdata);
            end
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Golden-trace checker: walks a synchronous trace ROM in step with the CPU commit stream
// and reports pass/fail, error count, first-error diagnostics and commit timeout.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT     = 1024,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    trace_len,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    input  logic [31:0]        commit_inst,
    input  logic               commit_rf_we,
    input  logic [4:0]         commit_rf_waddr,
    input  logic [31:0]        commit_rf_wdata,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [101:0]       rom_data,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [15:0]        err_count,
    output logic [ADDR_W:0]    first_err_idx,
    output logic [4:0]         first_err_mask
);

    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [MASK_W-1:0]  first_err_mask_q, first_err_mask_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;

    logic [MASK_W-1:0]  mask_c;
    logic [IDX_W-1:0]   idx_next;
    logic               mismatch;

    trace_record_cmp u_cmp (
        .rec_data        (rom_data),
        .commit_pc       (commit_pc),
        .commit_inst     (commit_inst),
        .commit_rf_we    (commit_rf_we),
        .commit_rf_waddr (commit_rf_waddr),
        .commit_rf_wdata (commit_rf_wdata),
        .mask_c          (mask_c)
    );

    assign idx_next = idx_q + IDX_W'(1);
    assign mismatch = |mask_c;

    // Next-state, counters and the look-ahead ROM address.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        len_d            = len_q;
        idle_d           = idle_q;
        err_count_d      = err_count_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_mask_d = first_err_mask_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        rom_addr         = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d            = '0;
                    len_d            = trace_len;
                    idle_d           = '0;
                    err_count_d      = '0;
                    first_err_idx_d  = '0;
                    first_err_mask_d = '0;
                    timeout_d        = 1'b0;
                    if (trace_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                // Fetch one record ahead on a commit so rom_data always holds record idx.
                rom_addr = commit_valid ? idx_next[ADDR_W-1:0] : idx_q[ADDR_W-1:0];
                if (commit_valid) begin
                    idx_d  = idx_next;
                    idle_d = '0;
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (err_count_q == '0) begin
                            first_err_idx_d  = idx_q;
                            first_err_mask_d = mask_c;
                        end
                    end
                    if (mismatch && STOP_ON_ERR) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end else if (idx_next == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_count_q == '0) && !mismatch;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            len_q            <= '0;
            idle_q           <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            first_err_mask_q <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            len_q            <= len_d;
            idle_q           <= idle_d;
            err_count_q      <= err_count_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_mask_q <= first_err_mask_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_mask = first_err_mask_q;

endmodule
